// File: rtl/conv_mc_serial.sv
// Serial multi-channel 2-D valid convolution: one signed MAC per clock, summed over
// channels, with optional ReLU and saturation to NBITS on each output pixel.
module conv_mc_serial #(
  parameter int NBITS  = 16,
  parameter int N      = 5,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CH     = 1,
  localparam int OUT   = (N - K) / STRIDE + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      relu_en,
  input  logic [CH*N*N*NBITS-1:0]   inputMAP,
  input  logic [CH*K*K*NBITS-1:0]   weights,
  output logic [OUT*OUT*NBITS-1:0]  outputMAP,
  output logic                      busy,
  output logic                      data_valid,
  output logic [1:0]                dbg_state
);

  localparam int ACCW = 2 * NBITS + $clog2(CH * K * K);
  localparam int P2   = 2 * NBITS;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int OW   = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int IW   = (CH * N * N > 1) ? $clog2(CH * N * N) : 1;
  localparam int WW   = (CH * K * K > 1) ? $clog2(CH * K * K) : 1;
  localparam int PW   = (OUT * OUT > 1) ? $clog2(OUT * OUT) : 1;

  localparam logic [KW-1:0] K_L = KW'(K - 1);
  localparam logic [CW-1:0] C_L = CW'(CH - 1);
  localparam logic [OW-1:0] O_L = OW'(OUT - 1);

  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((N - K) % STRIDE != 0) begin : g_bad_stride
    $error("conv_mc_serial: (N-K) must be a multiple of STRIDE");
  end

  logic [1:0]              state;
  logic [KW-1:0]           kx, ky;
  logic [CW-1:0]           c;
  logic [OW-1:0]           ox, oy;
  logic signed [ACCW-1:0]  acc, r;
  logic signed [NBITS-1:0] in_mem [CH*N*N];
  logic signed [NBITS-1:0] w_mem  [CH*K*K];
  logic signed [NBITS-1:0] stage  [OUT*OUT];
  logic                    relu_r;
  logic [IW-1:0]           in_idx;
  logic [WW-1:0]           w_idx;
  logic [PW-1:0]           pix;
  logic signed [NBITS-1:0] a, b, res;
  logic signed [P2-1:0]    prod;
  logic                    pix_end, job_end;
  logic [OUT*OUT*NBITS-1:0] out_next;

  // Window element for the current loop position; all terms fit in the index width.
  assign in_idx = IW'(c) * IW'(N * N)
                + (IW'(oy) * IW'(STRIDE) + IW'(ky)) * IW'(N)
                + IW'(ox) * IW'(STRIDE) + IW'(kx);
  assign w_idx  = WW'(c) * WW'(K * K) + WW'(ky) * WW'(K) + WW'(kx);
  assign pix    = PW'(oy) * PW'(OUT) + PW'(ox);

  assign a    = in_mem[in_idx];
  assign b    = w_mem[w_idx];
  assign prod = P2'(a) * P2'(b);
  assign r    = acc + ACCW'(prod);

  assign pix_end = (kx == K_L) && (ky == K_L) && (c == C_L);
  assign job_end = pix_end && (ox == O_L) && (oy == O_L);

  always_comb begin
    if (relu_r && r[ACCW-1])
      res = '0;
    else if (r > MAXV)
      res = {1'b0, {(NBITS-1){1'b1}}};
    else if (r < MINV)
      res = {1'b1, {(NBITS-1){1'b0}}};
    else
      res = r[NBITS-1:0];
  end

  // The final pixel is still in flight on the completion edge, so it bypasses the buffer.
  always_comb begin
    out_next = '0;
    for (int i = 0; i < OUT * OUT; i++)
      out_next[i*NBITS +: NBITS] = (i == OUT * OUT - 1) ? res : stage[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      kx        <= '0;
      ky        <= '0;
      c         <= '0;
      ox        <= '0;
      oy        <= '0;
      outputMAP <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (pix_end) acc <= '0;
          else         acc <= r;
          if (kx != K_L) kx <= kx + 1'b1;
          else begin
            kx <= '0;
            if (ky != K_L) ky <= ky + 1'b1;
            else begin
              ky <= '0;
              if (c != C_L) c <= c + 1'b1;
              else begin
                c <= '0;
                if (ox != O_L) ox <= ox + 1'b1;
                else begin
                  ox <= '0;
                  if (oy != O_L) oy <= oy + 1'b1;
                  else           oy <= '0;
                end
              end
            end
          end
          if (job_end) begin
            outputMAP <= out_next;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Job operands and the staging buffer are pure data; they need no reset.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && start) begin
      for (int i = 0; i < CH * N * N; i++) in_mem[i] <= inputMAP[i*NBITS +: NBITS];
      for (int i = 0; i < CH * K * K; i++) w_mem[i] <= weights[i*NBITS +: NBITS];
      relu_r <= relu_en;
    end
    if (!reset && state == RUN && pix_end)
      stage[pix] <= res;
  end

  assign busy       = (state == RUN) || (state == DONE);
  assign data_valid = (state == DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_conv_mc_serial.sv
// Bench for conv_mc_serial: default, stride-2 and two-channel instances checked
// against a direct arithmetic convolution model held in the bench.
module tb_conv_mc_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         relu_en = 1'b0;
  logic         start = 1'b0, start_s2 = 1'b0, start_c2 = 1'b0;
  logic [399:0] in_map = '0;
  logic [143:0] w = '0;
  logic [799:0] in_c2 = '0;
  logic [287:0] w_c2 = '0;
  logic [143:0] out_map, out_c2;
  logic [63:0]  out_s2;
  logic         busy, dv, busy_s2, dv_s2, busy_c2, dv_c2;
  logic [1:0]   st, st_s2, st_c2;

  conv_mc_serial dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .inputMAP(in_map), .weights(w), .outputMAP(out_map),
    .busy(busy), .data_valid(dv), .dbg_state(st));

  conv_mc_serial #(.STRIDE(2)) dut_s2 (
    .clk(clk), .reset(reset), .start(start_s2), .relu_en(relu_en),
    .inputMAP(in_map), .weights(w), .outputMAP(out_s2),
    .busy(busy_s2), .data_valid(dv_s2), .dbg_state(st_s2));

  conv_mc_serial #(.CH(2)) dut_c2 (
    .clk(clk), .reset(reset), .start(start_c2), .relu_en(relu_en),
    .inputMAP(in_c2), .weights(w_c2), .outputMAP(out_c2),
    .busy(busy_c2), .data_valid(dv_c2), .dbg_state(st_c2));

  int checks = 0;
  int errors = 0;
  int gmap [50];
  int gw   [18];
  int gres [9];
  int exp1 [9] = '{312, 348, 384, 492, 528, 564, 672, 708, 744};
  int exp2 [4] = '{312, 384, 672, 744};

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: valid convolution straight from the definition, then ReLU / saturate.
  task automatic golden(input int ch, input int stride, input int relu);
    int out;
    longint s;
    out = (5 - 3) / stride + 1;
    for (int oy = 0; oy < out; oy++)
      for (int ox = 0; ox < out; ox++) begin
        s = 0;
        for (int c = 0; c < ch; c++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              s += longint'(gmap[(c*5 + oy*stride + ky)*5 + ox*stride + kx]) * gw[(c*3 + ky)*3 + kx];
        if (relu != 0 && s < 0) s = 0;
        else if (s > 32767)     s = 32767;
        else if (s < -32768)    s = -32768;
        gres[oy*out + ox] = int'(s);
      end
  endtask

  task automatic load_buses();
    int t;
    for (int i = 0; i < 50; i++) begin
      t = gmap[i];
      if (i < 25) in_map[i*16 +: 16] = t[15:0];
      in_c2[i*16 +: 16] = t[15:0];
    end
    for (int i = 0; i < 18; i++) begin
      t = gw[i];
      if (i < 9) w[i*16 +: 16] = t[15:0];
      w_c2[i*16 +: 16] = t[15:0];
    end
  endtask

  function automatic int pix_of(input int which, input int i);
    if (which == 0) return int'($signed(out_map[i*16 +: 16]));
    if (which == 1) return int'($signed(out_s2[i*16 +: 16]));
    return int'($signed(out_c2[i*16 +: 16]));
  endfunction

  function automatic logic dv_of(input int which);
    if (which == 0) return dv;
    if (which == 1) return dv_s2;
    return dv_c2;
  endfunction

  function automatic logic busy_of(input int which);
    if (which == 0) return busy;
    if (which == 1) return busy_s2;
    return busy_c2;
  endfunction

  task automatic check_out(input int which, input int npix, input string tag);
    for (int i = 0; i < npix; i++)
      check($sformatf("%s_pix%0d", tag, i), pix_of(which, i), gres[i]);
  endtask

  // Single job on an auxiliary instance: latency, pulse width, result.
  task automatic run_aux(input int which, input int m, input string tag);
    int cnt;
    @(negedge clk);
    if (which == 1) start_s2 = 1'b1; else start_c2 = 1'b1;
    @(posedge clk); #1;
    start_s2 = 1'b0; start_c2 = 1'b0;
    cnt = 0;
    while (cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      if (dv_of(which)) break;
    end
    check({tag, "_latency"}, cnt, m);
    check_out(which, (which == 1) ? 4 : 9, tag);
    @(posedge clk); #1;
    check({tag, "_dv_width"}, dv_of(which), 0);
    check({tag, "_busy_after"}, busy_of(which), 0);
  endtask

  // Default-instance job with optional re-start pulse, mid-run input change or reset.
  task automatic run_main(input int restart_at, input int change_at, input int reset_at,
                          input string tag);
    int dv_cnt, first;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dv_cnt = 0;
    first = -1;
    for (int e = 1; e <= 85; e++) begin
      @(posedge clk); #1;
      if (dv) begin
        dv_cnt++;
        if (first < 0) first = e;
      end
      if (reset_at > 0 && e == reset_at + 1) begin
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_dv"}, dv, 0);
        for (int i = 0; i < 9; i++) check($sformatf("%s_rst_out%0d", tag, i), pix_of(0, i), 0);
        reset = 1'b0;
      end
      if (e == restart_at) start = 1'b1;
      if (e == restart_at + 1) start = 1'b0;
      if (e == change_at)
        for (int i = 0; i < 25; i++) in_map[i*16 +: 16] = 16'($urandom);
      if (reset_at > 0 && e == reset_at) reset = 1'b1;
    end
    if (reset_at > 0) check({tag, "_dv_count"}, dv_cnt, 0);
    else begin
      check({tag, "_dv_count"}, dv_cnt, 1);
      check({tag, "_latency"}, first, 81);
      check_out(0, 9, tag);
    end
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic set_test1(input int ch);
    for (int c = 0; c < ch; c++) begin
      for (int i = 0; i < 25; i++) gmap[c*25 + i] = i;
      for (int i = 0; i < 9; i++)  gw[c*9 + i] = i;
    end
  endtask

  task automatic set_const(input int mv, input int wv);
    for (int i = 0; i < 50; i++) gmap[i] = mv;
    for (int i = 0; i < 18; i++) gw[i] = wv;
  endtask

  task automatic set_random();
    for (int i = 0; i < 50; i++) gmap[i] = int'($urandom_range(300, 0)) - 150;
    for (int i = 0; i < 18; i++) gw[i] = int'($urandom_range(300, 0)) - 150;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rl;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_dv", dv, 0);
    check("reset_state", st, 0);
    check("reset_out0", pix_of(0, 0), 0);
    check("reset_out8", pix_of(0, 8), 0);
    @(negedge clk);
    reset = 1'b0;

    // Scenario 1: ramp map and weights
    set_test1(1);
    load_buses();
    relu_en = 1'b0;
    golden(1, 1, 0);
    run_main(0, 0, 0, "t1");
    for (int i = 0; i < 9; i++) check($sformatf("t1_const%0d", i), pix_of(0, i), exp1[i]);

    // Scenario 2: stride 2
    golden(1, 2, 0);
    run_aux(1, 36, "t2");
    for (int i = 0; i < 4; i++) check($sformatf("t2_const%0d", i), pix_of(1, i), exp2[i]);

    // Scenario 3: two identical channels
    set_test1(2);
    load_buses();
    golden(2, 1, 0);
    run_aux(2, 162, "t3");
    check("t3_const0", pix_of(2, 0), 624);
    check("t3_const8", pix_of(2, 8), 1488);

    // Scenario 4: saturation and ReLU
    set_const(1000, 1000);
    load_buses();
    golden(1, 1, 0);
    run_main(0, 0, 0, "t4_pos");
    check("t4_pos_const", pix_of(0, 4), 32767);
    set_const(1000, -1000);
    load_buses();
    golden(1, 1, 0);
    run_main(0, 0, 0, "t4_neg");
    check("t4_neg_const", pix_of(0, 4), -32768);
    relu_en = 1'b1;
    golden(1, 1, 1);
    run_main(0, 0, 0, "t4_relu");
    check("t4_relu_const", pix_of(0, 4), 0);
    relu_en = 1'b0;

    // Scenario 5: ignored re-start, mid-run input change, reset abort
    set_test1(1);
    load_buses();
    golden(1, 1, 0);
    run_main(10, 20, 0, "t5_ctl");
    load_buses();
    run_main(0, 0, 40, "t5_rst");
    load_buses();
    run_main(0, 0, 0, "t5_fresh");
    for (int i = 0; i < 9; i++) check($sformatf("t5_const%0d", i), pix_of(0, i), exp1[i]);

    // Scenario 6: back-to-back jobs, then randomized jobs on all instances
    set_test1(1);
    load_buses();
    golden(1, 1, 0);
    run_main(0, 0, 0, "t6_a");
    set_const(1000, 1000);
    load_buses();
    golden(1, 1, 0);
    run_main(0, 0, 0, "t6_b");
    set_const(1000, -1000);
    load_buses();
    relu_en = 1'b1;
    golden(1, 1, 1);
    run_main(0, 0, 0, "t6_c");
    for (int j = 0; j < 6; j++) begin
      set_random();
      load_buses();
      rl = int'($urandom_range(1, 0));
      relu_en = rl[0];
      golden(1, 1, rl);
      run_main(0, 0, 0, $sformatf("rnd%0d_main", j));
      golden(1, 2, rl);
      run_aux(1, 36, $sformatf("rnd%0d_s2", j));
      golden(2, 1, rl);
      run_aux(2, 162, $sformatf("rnd%0d_c2", j));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
